// File: rtl/double_threshold_hysteresis.sv
// rtl/double_threshold_hysteresis.sv - Canny double threshold + single-pass 3x3 hysteresis on a raster NMS stream
// Optional build macro DT_WEAK_OUT_EN: weak pixels without a strong neighbour emit 128 instead of 0.
module double_threshold_hysteresis #(
    parameter int IMG_WIDTH  = 506,
    parameter int IMG_HEIGHT = 506,
    parameter int MAG_W      = 11,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [MAG_W-1:0] nms_magnitude,
    input  logic             nms_valid,
    input  logic [MAG_W-1:0] high_thresh,
    input  logic [MAG_W-1:0] low_thresh,
    output logic [7:0]       edge_pixel,
    output logic             edge_pixel_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] edge_count
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
`ifdef DT_WEAK_OUT_EN
    localparam logic [7:0] WEAK_VAL = 8'd128;
`else
    localparam logic [7:0] WEAK_VAL = 8'd0;
`endif

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [MAG_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [5:0]       wc0_q, wc0_d, wc1_q, wc1_d, wc2_q, wc2_d;
    logic             win_v_q, win_v_d, win_last_q, win_last_d;
    logic [7:0]       px1_q, px1_d;
    logic             px1_v_q, px1_v_d, px1_last_q, px1_last_d;
    logic [7:0]       edge_pixel_q, edge_pixel_d;
    logic             edge_v_q, edge_v_d, out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, edge_count_q, edge_count_d;

    logic [1:0] lb0_mem [IMG_WIDTH];
    logic [1:0] lb1_mem [IMG_WIDTH];

    logic             first_px;
    logic [MAG_W-1:0] h_sel, l_sel, l_eff;
    logic [1:0]       code, lb_top, lb_mid, centre;
    logic             nb_strong, px1_is_edge;

    always_comb begin
        first_px = (row_q == '0) && (col_q == '0);
        // The first pixel of a frame must already use the thresholds being latched with it.
        h_sel    = first_px ? high_thresh : hi_q;
        l_sel    = first_px ? low_thresh : lo_q;
        l_eff    = (l_sel > h_sel) ? h_sel : l_sel;
        if (nms_magnitude >= h_sel)      code = 2'd2;
        else if (nms_magnitude >= l_eff) code = 2'd1;
        else                             code = 2'd0;
        lb_top = lb1_mem[col_q];
        lb_mid = lb0_mem[col_q];

        col_d      = col_q;
        row_d      = row_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        wc0_d      = wc0_q;
        wc1_d      = wc1_q;
        wc2_d      = wc2_q;
        win_v_d    = 1'b0;
        win_last_d = 1'b0;
        if (nms_valid) begin
            if (first_px) begin
                hi_d = high_thresh;
                lo_d = low_thresh;
            end
            wc0_d      = wc1_q;
            wc1_d      = wc2_q;
            wc2_d      = {lb_top, lb_mid, code};
            win_v_d    = (row_q >= RW'(2)) && (col_q >= CW'(2));
            win_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // Window columns are {row r-2, row r-1, row r}; wc1 is the centre column.
        centre    = wc1_q[3:2];
        nb_strong = wc0_q[5] | wc0_q[3] | wc0_q[1] | wc2_q[5] | wc2_q[3] | wc2_q[1]
                  | wc1_q[5] | wc1_q[1];
        if (centre == 2'd2)                  px1_d = 8'd255;
        else if (centre == 2'd1 && nb_strong) px1_d = 8'd255;
        else if (centre == 2'd1)              px1_d = WEAK_VAL;
        else                                  px1_d = 8'd0;
        px1_v_d    = win_v_q;
        px1_last_d = win_v_q & win_last_q;

        px1_is_edge  = px1_v_q && (px1_q == 8'd255);
        edge_v_d     = px1_v_q;
        edge_pixel_d = px1_v_q ? px1_q : edge_pixel_q;
        out_last_d   = px1_last_q;
        frame_done_d = out_last_q;
        edge_count_d = edge_count_q;
        run_cnt_d    = run_cnt_q + (px1_is_edge ? CNT_W'(1) : CNT_W'(0));
        if (out_last_q) begin
            edge_count_d = run_cnt_q;
            run_cnt_d    = px1_is_edge ? CNT_W'(1) : CNT_W'(0);
        end
    end

    always_ff @(posedge clk) begin
        if (rstN) begin
            col_q        <= '0;
            row_q        <= '0;
            win_v_q      <= 1'b0;
            win_last_q   <= 1'b0;
            px1_v_q      <= 1'b0;
            px1_last_q   <= 1'b0;
            edge_v_q     <= 1'b0;
            edge_pixel_q <= 8'd0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            run_cnt_q    <= '0;
            edge_count_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_v_q      <= win_v_d;
            win_last_q   <= win_last_d;
            px1_v_q      <= px1_v_d;
            px1_last_q   <= px1_last_d;
            edge_v_q     <= edge_v_d;
            edge_pixel_q <= edge_pixel_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            run_cnt_q    <= run_cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        wc0_q <= wc0_d;
        wc1_q <= wc1_d;
        wc2_q <= wc2_d;
        px1_q <= px1_d;
        if (nms_valid && !rstN) begin
            lb1_mem[col_q] <= lb_mid;
            lb0_mem[col_q] <= code;
        end
    end

    assign edge_pixel       = edge_pixel_q;
    assign edge_pixel_valid = edge_v_q;
    assign frame_done       = frame_done_q;
    assign edge_count       = edge_count_q;

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// tb/tb_double_threshold_hysteresis.sv - directed-frame bench with image-level reference model
module tb_double_threshold_hysteresis;
    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rstN;
    logic [10:0] nms_magnitude, high_thresh, low_thresh;
    logic        nms_valid;
    logic [7:0]  edge_pixel;
    logic        edge_pixel_valid, frame_done;
    logic [19:0] edge_count;

    always #5 clk = ~clk;

    double_threshold_hysteresis #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(11), .CNT_W(20)) dut (
        .clk(clk), .rstN(rstN), .nms_magnitude(nms_magnitude), .nms_valid(nms_valid),
        .high_thresh(high_thresh), .low_thresh(low_thresh), .edge_pixel(edge_pixel),
        .edge_pixel_valid(edge_pixel_valid), .frame_done(frame_done), .edge_count(edge_count));

    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    bit exp_v[int];
    int exp_px[int];
    bit exp_fd[int];
    int exp_fdc[int];
    bit rst_e[int];
    int mag_img[H][W];
    int cimg[H][W];
    int mr = 0, mc = 0, mh = 0, ml = 0, fcnt = 0, hi_in = 200, lo_in = 80;
    int acc22 = -1, first_v = -1;
    bit armed = 0;
    int last_px = 0, cur_cnt = 0, obs_n = 0, obs255 = 0;
    int fr255[$];
    int frn[$];
    int weak_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    function automatic int cls(input int m);
        int l;
        l = (ml > mh) ? mh : ml;
        return (m >= mh) ? 2 : ((m >= l) ? 1 : 0);
    endfunction

    task automatic px(input int m, input bit v);
        int cr, cc, val;
        bit nb;
        @(negedge clk);
        rstN          = 1'b0;
        nms_magnitude = m[10:0];
        nms_valid     = v;
        high_thresh   = hi_in[10:0];
        low_thresh    = lo_in[10:0];
        if (v) begin
            if (mr == 0 && mc == 0) begin
                mh = hi_in;
                ml = lo_in;
            end
            cimg[mr][mc] = cls(m);
            if (mr == 2 && mc == 2 && acc22 < 0) acc22 = edge_n + 1;
            if (mr >= 2 && mc >= 2) begin
                cr = mr - 1;
                cc = mc - 1;
                nb = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && cimg[cr+dr][cc+dc] == 2) nb = 1;
                if (cimg[cr][cc] == 2)            val = 255;
                else if (cimg[cr][cc] == 1 && nb) val = 255;
                else if (cimg[cr][cc] == 1)       val = weak_val;
                else                              val = 0;
                exp_v[edge_n + 3]  = 1;
                exp_px[edge_n + 3] = val;
                if (val == 255) fcnt++;
                if (mr == H - 1 && mc == W - 1) begin
                    exp_fd[edge_n + 4]  = 1;
                    exp_fdc[edge_n + 4] = fcnt;
                    fcnt = 0;
                end
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN      = 1'b1;
        nms_valid = 1'b0;
        rst_e[edge_n + 1] = 1;
        for (int k = edge_n + 1; k <= edge_n + 6; k++) begin
            exp_v.delete(k);
            exp_px.delete(k);
            exp_fd.delete(k);
            exp_fdc.delete(k);
        end
        mr = 0;
        mc = 0;
        fcnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0);
    endtask

    task automatic fill(input int m);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mag_img[r][c] = m;
    endtask

    task automatic send_frame(input bit gaps, input int chg_at, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (i == chg_at) hi_in = 255;
            if (gaps) px(0, 0);
            px(mag_img[i / W][i % W], 1);
        end
    endtask

    always begin
        @(posedge clk);
        edge_n++;
        #1;
        if (rst_e.exists(edge_n)) begin
            armed = 1;
            chk("rst_valid", {31'b0, edge_pixel_valid}, 0);
            chk("rst_pixel", {24'b0, edge_pixel}, 0);
            chk("rst_frame_done", {31'b0, frame_done}, 0);
            chk("rst_edge_count", {12'b0, edge_count}, 0);
            last_px = 0;
            cur_cnt = 0;
            obs_n   = 0;
            obs255  = 0;
        end else if (armed) begin
            chk("valid", {31'b0, edge_pixel_valid}, exp_v.exists(edge_n) ? 1 : 0);
            if (exp_v.exists(edge_n)) begin
                chk("pixel", {24'b0, edge_pixel}, exp_px[edge_n]);
                last_px = exp_px[edge_n];
            end else begin
                chk("pixel_hold", {24'b0, edge_pixel}, last_px);
            end
            if (edge_pixel_valid === 1'b1) begin
                if (first_v < 0) first_v = edge_n;
                obs_n++;
                if (edge_pixel == 8'd255) obs255++;
            end
            chk("frame_done", {31'b0, frame_done}, exp_fd.exists(edge_n) ? 1 : 0);
            if (exp_fd.exists(edge_n)) cur_cnt = exp_fdc[edge_n];
            chk("edge_count", {12'b0, edge_count}, cur_cnt);
            if (frame_done === 1'b1) begin
                fr255.push_back(obs255);
                frn.push_back(obs_n);
                obs255 = 0;
                obs_n  = 0;
            end
        end
    end

    initial begin
        int e255[6];
        e255 = '{36, 0, 2, 2, 36, 36};
`ifdef DT_WEAK_OUT_EN
        weak_val = 128;
`else
        weak_val = 0;
`endif
        rstN = 1'b1;
        nms_valid = 1'b0;
        nms_magnitude = '0;
        high_thresh = 11'd200;
        low_thresh = 11'd80;
        do_reset();
        idle(2);

        fill(300);
        send_frame(0, -1, 64);
        fill(100);
        send_frame(0, -1, 64);
        idle(8);

        fill(0);
        mag_img[3][3] = 250;
        mag_img[3][4] = 120;
        mag_img[5][5] = 80;
        send_frame(0, -1, 64);
        send_frame(1, -1, 64);
        idle(8);

        hi_in = 50;
        lo_in = 150;
        fill(100);
        send_frame(0, 20, 64);
        idle(8);
        hi_in = 200;
        lo_in = 80;

        fill(300);
        send_frame(0, -1, 36);
        do_reset();
        send_frame(0, -1, 64);
        idle(8);

        chk("latency_first_out", first_v - acc22, 2);
        chk("frame_total", fr255.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < fr255.size()) begin
                chk("frame_edges", fr255[i], e255[i]);
                chk("frame_outputs", frn[i], 36);
            end
        end
        chk("final_edge_count", {12'b0, edge_count}, 36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
